mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_rr_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the SDRAM client arbiter.
// The optional watchdog is enabled with MEM_ARB_WDOG_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] BANK_PP_A = 2'b01;
  localparam logic [1:0] BANK_PP_B = 2'b10;
  localparam logic [1:0] BANK_PED  = 2'b00;

  localparam int DEF_N_CLI   = 4;
  localparam int DEF_DATA_W  = 14;
  localparam int DEF_TIMEOUT = 4096;

  localparam int ROW_W = 13;
  localparam int MEM_W = 16;

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around to index 0.
module mem_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N_CLI = DEF_N_CLI,
  parameter int PW    = $clog2(N_CLI)
) (
  input  logic [N_CLI-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    idx,
  output logic             any
);

  logic [PW-1:0] j;

  // Walk downward so the candidate closest to ptr is written last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = N_CLI - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % N_CLI);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin SDRAM arbiter with ping-pong frame banks.
// Define MEM_ARB_WDOG_EN to add the burst watchdog and ERR_TIMEOUT.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CLI   = DEF_N_CLI,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    CLK100,
  input  logic                    RESET,
  input  logic [N_CLI-1:0]        CLI_REQ,
  input  logic [N_CLI-1:0]        CLI_WR,
  input  logic [N_CLI*2-1:0]      CLI_BANK,
  input  logic [N_CLI*ROW_W-1:0]  CLI_ROW,
  input  logic [N_CLI*DATA_W-1:0] CLI_WDATA,
  output logic [DATA_W-1:0]       CLI_RDATA,
  output logic [N_CLI-1:0]        CLI_BUF_EN,
  output logic [N_CLI-1:0]        CLI_DONE,
  input  logic                    FRAME_TICK,
  output logic [1:0]              WR_BANK,
  output logic [1:0]              RD_BANK,
  output logic                    C_READ,
  output logic                    C_WRITE,
  output logic [1:0]              C_BANK,
  output logic [ROW_W-1:0]        C_ROW_ADDRESS,
  output logic [MEM_W-1:0]        DATA_MEM_OUT,
  input  logic [MEM_W-1:0]        DATA_MEM_IN,
  input  logic                    BUF_EN,
  input  logic                    END_OPERATION,
  output logic                    ERR_TIMEOUT
);

  localparam int PW = $clog2(N_CLI);

  state_t             state, state_nx;
  logic [N_CLI-1:0]   pending;
  logic [PW-1:0]      ptr, grant, pick_idx;
  logic               pick_any;
  logic               wr_q;
  logic [1:0]         bank_q;
  logic [ROW_W-1:0]   row_q;
  logic [1:0]         wr_bank;
  logic               active, wdog_hit;
  logic [DATA_W-1:0]  wdata_sel;
  logic               unused_mem_in;

  assign active = (state == ST_ACTIVE);

  mem_rr_pick #(.N_CLI(N_CLI), .PW(PW)) u_pick (
    .req (pending | CLI_REQ),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (pick_any) state_nx = ST_ACTIVE;
      ST_ACTIVE: if (END_OPERATION || wdog_hit) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100 or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      pending <= '0;
      ptr     <= '0;
      grant   <= '0;
      wr_q    <= 1'b0;
      bank_q  <= BANK_PED;
      row_q   <= '0;
      wr_bank <= BANK_PP_A;
    end else begin
      state <= state_nx;
      // A fresh request in the DONE cycle survives the clear.
      pending <= (pending & ~CLI_DONE) | CLI_REQ;
      if (state == ST_IDLE && pick_any) begin
        grant  <= pick_idx;
        wr_q   <= CLI_WR[pick_idx];
        bank_q <= CLI_BANK[pick_idx*2 +: 2];
        row_q  <= CLI_ROW[pick_idx*ROW_W +: ROW_W];
      end
      if (state == ST_DONE)
        ptr <= (grant == PW'(N_CLI - 1)) ? '0 : grant + 1'b1;
      if (FRAME_TICK)
        wr_bank <= (wr_bank == BANK_PP_A) ? BANK_PP_B : BANK_PP_A;
    end
  end

  always_comb begin
    CLI_BUF_EN = '0;
    CLI_DONE   = '0;
    for (int i = 0; i < N_CLI; i++) begin
      CLI_BUF_EN[i] = BUF_EN && active && (grant == PW'(i));
      CLI_DONE[i]   = (state == ST_DONE) && (grant == PW'(i));
    end
  end

  assign wdata_sel     = CLI_WDATA[grant*DATA_W +: DATA_W];
  assign C_WRITE       = active && wr_q;
  assign C_READ        = active && !wr_q;
  assign C_BANK        = active ? bank_q : BANK_PED;
  assign C_ROW_ADDRESS = active ? row_q : '0;
  assign DATA_MEM_OUT  = C_WRITE ? MEM_W'(wdata_sel) : '0;
  assign CLI_RDATA     = C_READ ? DATA_MEM_IN[DATA_W-1:0] : '0;
  assign unused_mem_in = ^{DATA_MEM_IN, 1'b0};

  assign WR_BANK = wr_bank;
  assign RD_BANK = (wr_bank == BANK_PP_A) ? BANK_PP_B : BANK_PP_A;

`ifdef MEM_ARB_WDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // Fires on the TIMEOUT-th ACTIVE cycle of a burst.
  assign wdog_hit = active && !END_OPERATION &&
                    (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK100 or posedge RESET) begin
    if (RESET) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= active ? wd_cnt + 1'b1 : '0;
      if (wdog_hit) err_q <= 1'b1;
    end
  end

  assign ERR_TIMEOUT = err_q;
`else
  localparam int unused_timeout = TIMEOUT;

  assign wdog_hit    = 1'b0;
  assign ERR_TIMEOUT = 1'b0;
`endif

endmodule
